// File: rtl/store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_unit: aligns SB/SH/SW into byte lanes, buffers them in order and   |
// | issues them to the data-memory write port.          Revision: 1.0        |
// +--------------------------------------------------------------------------+
module store_unit #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_valid_i,
   output logic              st_ready_o,
   input  logic [2:0]        func3_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              err_o,
   output logic              empty_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [3:0]        mem_wstrb_o,
   input  logic              mem_ack_i
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W:0]      count_q, count_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]    rd_nxt;
   logic                mem_req_q, mem_req_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]          mem_wstrb_q, mem_wstrb_d;
   logic                err_q, err_d;

   logic [ADDR_W-3:0]   buf_addr_q [DEPTH];
   logic [DATA_W-1:0]   buf_data_q [DEPTH];
   logic [3:0]          buf_strb_q [DEPTH];

   logic                al_legal;
   logic [3:0]          al_strb;
   logic [DATA_W-1:0]   al_data;
   logic [1:0]          a;
   logic                accept;
   logic                push;
   logic                pop;

   assign a          = addr_i[1:0];
   assign st_ready_o = (count_q < CNT_FULL);
   assign accept     = st_valid_i && st_ready_o;
   assign push       = accept && al_legal;
   assign pop        = (state_q == REQ) && mem_ack_i;
   assign rd_nxt     = rd_ptr_q + 1'b1;

   always_comb begin
      al_legal = 1'b0;
      al_strb  = 4'b0000;
      al_data  = wdata_i;
      case (func3_i)
         3'b000: begin
            al_legal = 1'b1;
            al_strb  = 4'b0001 << a;
            al_data  = {4{wdata_i[7:0]}};
         end
         3'b001: begin
            al_legal = ~a[0];
            al_strb  = a[1] ? 4'b1100 : 4'b0011;
            al_data  = {2{wdata_i[15:0]}};
         end
         3'b010: begin
            al_legal = (a == 2'b00);
            al_strb  = 4'b1111;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      err_d       = accept && !al_legal;
      wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d    = pop ? rd_nxt : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // The in-flight entry stays at the head until acked; count includes it.
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               state_d     = REQ;
               mem_req_d   = 1'b1;
               mem_addr_d  = {buf_addr_q[rd_ptr_q], 2'b00};
               mem_wdata_d = buf_data_q[rd_ptr_q];
               mem_wstrb_d = buf_strb_q[rd_ptr_q];
            end
         end
         REQ: begin
            if (mem_ack_i) begin
               if (count_q > CNT_ONE) begin
                  mem_addr_d  = {buf_addr_q[rd_nxt], 2'b00};
                  mem_wdata_d = buf_data_q[rd_nxt];
                  mem_wstrb_d = buf_strb_q[rd_nxt];
               end else if (push) begin
                  // Sole entry retires while a new one arrives: forward it directly.
                  mem_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                  mem_wdata_d = al_data;
                  mem_wstrb_d = al_strb;
               end else begin
                  state_d     = IDLE;
                  mem_req_d   = 1'b0;
                  mem_wstrb_d = 4'b0000;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= 4'b0000;
         err_q       <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_addr_q[i] <= '0;
            buf_data_q[i] <= '0;
            buf_strb_q[i] <= 4'b0000;
         end
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         err_q       <= err_d;
         if (push) begin
            buf_addr_q[wr_ptr_q] <= addr_i[ADDR_W-1:2];
            buf_data_q[wr_ptr_q] <= al_data;
            buf_strb_q[wr_ptr_q] <= al_strb;
         end
      end
   end

   assign empty_o     = (count_q == '0) && (state_q == IDLE);
   assign mem_req_o   = mem_req_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_wstrb_o = mem_wstrb_q;
   assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_store_unit: scoreboard bench for store_unit with a byte-lane model.   |
// |                                                     Revision: 1.0        |
// +--------------------------------------------------------------------------+
module tb_store_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid_i;
   logic        st_ready_o;
   logic [2:0]  func3_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        err_o;
   logic        empty_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_wstrb_o;
   logic        mem_ack_i;

   store_unit #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .st_valid_i  (st_valid_i),
      .st_ready_o  (st_ready_o),
      .func3_i     (func3_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .err_o       (err_o),
      .empty_o     (empty_o),
      .mem_req_o   (mem_req_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_wstrb_o (mem_wstrb_o),
      .mem_ack_i   (mem_ack_i)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_pass  = 0;
   logic err_exp = 1'b0;
   int   ack_mode = 3;   // 0 low, 1 high, 2 random, 3 driven by the stimulus

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // A store of size sz covers bytes addr..addr+sz-1; lane i carries byte (i mod sz) of rs2.
   function automatic exp_t model(input logic [2:0] f, input logic [31:0] ad,
                                  input logic [31:0] d, output bit legal);
      exp_t        e;
      int unsigned sz;
      int unsigned off;
      sz    = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : (f == 3'd2) ? 4 : 0;
      off   = ad % 4;
      legal = (sz != 0) && ((off % (sz == 0 ? 1 : sz)) == 0);
      e.addr = ad - off;
      e.data = '0;
      e.strb = '0;
      if (legal) begin
         for (int i = 0; i < 4; i++) begin
            e.data[8*i +: 8] = d[8*(i % sz) +: 8];
            e.strb[i]        = (i >= off) && (i < off + sz);
         end
      end
      return e;
   endfunction

   // Scoreboard / monitor: checks first, then applies this cycle's handshakes.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         err_exp = 1'b0;
      end else begin
         exp_t e;
         bit   legal;
         chk("ready", st_ready_o, q.size() < DEPTH);
         chk("empty", empty_o, q.size() == 0);
         chk("err", err_o, err_exp);
         if (q.size() == 0) begin
            chk("req_without_store", mem_req_o, 0);
         end else if (mem_req_o) begin
            chk("mem_addr", mem_addr_o, q[0].addr);
            chk("mem_wdata", mem_wdata_o, q[0].data);
            chk("mem_wstrb", mem_wstrb_o, q[0].strb);
            if (mem_ack_i) void'(q.pop_front());
         end
         if (!mem_req_o) chk("idle_wstrb", mem_wstrb_o, 0);
         err_exp = 1'b0;
         if (st_valid_i && st_ready_o) begin
            e = model(func3_i, addr_i, wdata_i, legal);
            if (legal) q.push_back(e);
            else       err_exp = 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      case (ack_mode)
         0: mem_ack_i = 1'b0;
         1: mem_ack_i = 1'b1;
         2: mem_ack_i = ($urandom_range(0, 2) != 0);
         default: ;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] f, input logic [31:0] ad, input logic [31:0] d);
      bit acc = 1'b0;
      st_valid_i = 1'b1;
      func3_i    = f;
      addr_i     = ad;
      wdata_i    = d;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         acc = st_ready_o;
         tick();
      end
      if (!acc) chk("accept_timeout", 0, 1);
      st_valid_i = 1'b0;
   endtask

   task automatic wait_empty();
      bit done = 1'b0;
      for (int n = 0; n < 500 && !done; n++) begin
         @(negedge clk);
         done = empty_o && (q.size() == 0);
      end
      chk("drain", done, 1);
      tick();
   endtask

   task automatic ack_pulse();
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      st_valid_i = 1'b0;
      func3_i    = 3'd0;
      addr_i     = '0;
      wdata_i    = '0;
      mem_ack_i  = 1'b0;
      #3;
      chk("rst_req", mem_req_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_wdata", mem_wdata_o, 0);
      chk("rst_wstrb", mem_wstrb_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_ready", st_ready_o, 1);
      chk("rst_empty", empty_o, 1);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // 1: SB to the top byte lane
      send(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
      tick();
      chk("t1_req", mem_req_o, 1);
      chk("t1_addr", mem_addr_o, 32'h0000_1000);
      chk("t1_wstrb", mem_wstrb_o, 4'b1000);
      chk("t1_wdata", mem_wdata_o, 32'hDDDD_DDDD);
      ack_pulse();
      chk("t1_req_after_ack", mem_req_o, 0);
      chk("t1_empty_after_ack", empty_o, 1);

      // 2: upper halfword, then misaligned SH and SW
      send(3'b001, 32'h0000_2002, 32'h1234_5678);
      tick();
      chk("t2_wstrb", mem_wstrb_o, 4'b1100);
      chk("t2_wdata", mem_wdata_o, 32'h5678_5678);
      ack_pulse();
      send(3'b001, 32'h0000_2001, 32'h1234_5678);
      chk("t2_sh_err", err_o, 1);
      tick();
      chk("t2_sh_err_clear", err_o, 0);
      chk("t2_sh_noreq", mem_req_o, 0);
      send(3'b010, 32'h0000_2002, 32'h1234_5678);
      chk("t2_sw_err", err_o, 1);
      tick();
      chk("t2_sw_err_clear", err_o, 0);
      chk("t2_sw_noreq", mem_req_o, 0);
      send(3'b011, 32'h0000_2000, 32'h1234_5678);
      chk("t2_func3_err", err_o, 1);
      tick();

      // 3: fill the buffer with ack held low
      for (int i = 0; i < 4; i++) send(3'b010, 32'(i * 4), 32'hC0DE_0000 + 32'(i));
      chk("t3_full_ready", st_ready_o, 0);
      st_valid_i = 1'b1;
      func3_i    = 3'b010;
      addr_i     = 32'h10;
      wdata_i    = 32'hC0DE_0004;
      tick();
      tick();
      tick();
      chk("t3_held_ready", st_ready_o, 0);
      ack_pulse();
      chk("t3_ready_after_ack", st_ready_o, 1);
      send(3'b010, 32'h10, 32'hC0DE_0004);
      ack_mode = 1;
      wait_empty();

      // 4: continuous pushes with ack every cycle
      for (int i = 0; i < 10; i++)
         send(3'(i % 3), 32'h3000 + 32'(i * 4), $urandom);
      wait_empty();

      // 5: reset mid-request with three entries queued
      ack_mode = 0;
      tick();
      for (int i = 0; i < 3; i++) send(3'b010, 32'h4000 + 32'(i * 4), 32'h5555_0000 + 32'(i));
      tick();
      tick();
      chk("t5_req_before_rst", mem_req_o, 1);
      rst = 1'b1;
      #1;
      chk("t5_rst_req", mem_req_o, 0);
      chk("t5_rst_wstrb", mem_wstrb_o, 0);
      chk("t5_rst_empty", empty_o, 1);
      chk("t5_rst_ready", st_ready_o, 1);
      tick();
      tick();
      rst = 1'b0;
      ack_mode = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t5_no_req_after_rst", mem_req_o, 0);
      end
      tick();

      // 6: random stores with random ack stalls
      ack_mode = 2;
      for (int i = 0; i < 20; i++) begin
         int          r;
         logic [2:0]  f;
         logic [31:0] ad;
         r  = $urandom_range(0, 9);
         f  = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
         ad = $urandom;
         if (f != 3'd0 && $urandom_range(0, 3) != 0) ad[1:0] = (f == 3'd1) ? {ad[1], 1'b0} : 2'b00;
         send(f, ad, $urandom);
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end
      ack_mode = 1;
      wait_empty();
      chk("final_sb_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
